// File: rtl/ds1302_pkg.sv
// Shared constants and state encoding for the DS1302 time writer.
// One frame = setup half + 32 shift halves + hold half + 4 gap halves.
package ds1302_pkg;

    localparam logic [7:0] CMD_SEC = 8'h80;
    localparam logic [7:0] CMD_MIN = 8'h82;
    localparam logic [7:0] CMD_HR  = 8'h84;
    localparam logic [7:0] CMD_WP  = 8'h8E;

    localparam int FRAME_HALVES = 38;
    localparam int GAP_HALVES   = 4;
    localparam int FRAME_BITS   = (FRAME_HALVES - GAP_HALVES - 2) / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CE_SETUP,
        ST_SHIFT,
        ST_CE_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ds1302_half_tick.sv
// Down-counter producing a one-cycle tick in the last cycle of every SCLK half-period.
module ds1302_half_tick #(
    parameter int SCLK_HALF = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart)
            cnt <= RELOAD;
        else if (cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/ds1302_time_writer.sv
// Writes hours/minutes/seconds to a DS1302 over its 3-wire bus, optionally
// clearing write-protect first.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start, bus released
// CE_SETUP  | ce high, bit 0 presented, one half-period before first rise
// SHIFT     | 16 bits LSB first, sclk low half then high half per bit
// CE_HOLD   | ce held one half-period after the last fall
// GAP       | ce low for four half-periods between frames
// DONE      | one-cycle completion pulse
module ds1302_time_writer
    import ds1302_pkg::*;
#(
    parameter int SCLK_HALF = 50,
    parameter bit CLEAR_WP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] hr_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    output logic       ce,
    output logic       sclk,
    output logic       io_out,
    output logic       io_oe,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] LAST_TXN = CLEAR_WP ? 2'd3 : 2'd2;
    localparam logic [1:0] REG_OFS  = CLEAR_WP ? 2'd0 : 2'd1;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [1:0] LAST_GAP = 2'(GAP_HALVES - 1);

    state_t      state, state_nx;
    logic [3:0]  bit_idx, bit_idx_nx;
    logic        phase, phase_nx;
    logic [1:0]  gap_cnt, gap_cnt_nx;
    logic [1:0]  txn, txn_nx;
    logic [7:0]  sec_q, min_q, hr_q;
    logic        tick;
    logic        accept;
    logic [1:0]  reg_sel;
    logic [15:0] frame;

    assign accept = (state == ST_IDLE) && start;

    ds1302_half_tick #(.SCLK_HALF(SCLK_HALF)) u_half_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    // Clock-halt and 12/24 bits are cleared once at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else if (accept) begin
            sec_q <= sec_bcd & 8'h7F;
            min_q <= min_bcd;
            hr_q  <= hr_bcd & 8'h3F;
        end
    end

    assign reg_sel = txn + REG_OFS;

    always_comb begin
        frame = {8'h00, CMD_WP};
        case (reg_sel)
            2'd1:    frame = {sec_q, CMD_SEC};
            2'd2:    frame = {min_q, CMD_MIN};
            2'd3:    frame = {hr_q,  CMD_HR};
            default: frame = {8'h00, CMD_WP};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            phase   <= 1'b0;
            gap_cnt <= '0;
            txn     <= '0;
        end else begin
            state   <= state_nx;
            bit_idx <= bit_idx_nx;
            phase   <= phase_nx;
            gap_cnt <= gap_cnt_nx;
            txn     <= txn_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_idx_nx = bit_idx;
        phase_nx   = phase;
        gap_cnt_nx = gap_cnt;
        txn_nx     = txn;
        ce         = 1'b0;
        sclk       = 1'b0;
        io_out     = 1'b0;
        io_oe      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx   = ST_CE_SETUP;
                    txn_nx     = '0;
                    bit_idx_nx = '0;
                    phase_nx   = 1'b0;
                    gap_cnt_nx = '0;
                end
            end
            ST_CE_SETUP: begin
                ce     = 1'b1;
                io_oe  = 1'b1;
                busy   = 1'b1;
                io_out = frame[bit_idx];
                if (tick) begin
                    state_nx = ST_SHIFT;
                    phase_nx = 1'b0;
                end
            end
            ST_SHIFT: begin
                ce     = 1'b1;
                io_oe  = 1'b1;
                busy   = 1'b1;
                sclk   = phase;
                io_out = frame[bit_idx];
                if (tick) begin
                    if (!phase) begin
                        phase_nx = 1'b1;
                    end else if (bit_idx == LAST_BIT) begin
                        state_nx = ST_CE_HOLD;
                        phase_nx = 1'b0;
                    end else begin
                        // data advances on the falling edge only
                        bit_idx_nx = bit_idx + 4'd1;
                        phase_nx   = 1'b0;
                    end
                end
            end
            ST_CE_HOLD: begin
                ce     = 1'b1;
                io_oe  = 1'b1;
                busy   = 1'b1;
                io_out = frame[bit_idx];
                if (tick) begin
                    state_nx   = ST_GAP;
                    gap_cnt_nx = '0;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (tick) begin
                    if (gap_cnt != LAST_GAP) begin
                        gap_cnt_nx = gap_cnt + 2'd1;
                    end else if (txn == LAST_TXN) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx   = ST_CE_SETUP;
                        txn_nx     = txn + 2'd1;
                        bit_idx_nx = '0;
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ds1302_time_writer.sv
// Bench for ds1302_time_writer: two instances (write-protect clear off/on) checked
// cycle by cycle against a frame/half-period arithmetic model plus literal frames.
module tb_ds1302_time_writer;

    localparam int H  = 2;
    localparam int FR = 38 * H;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] hr, mn, sc;
    logic [1:0] ce, sclk, io_out, io_oe, busy, done;

    int total = 0;
    int pass  = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    int         mt   [2] = '{0, 0};
    bit         mact [2] = '{1'b0, 1'b0};
    logic [7:0] ms [2], mm [2], mh [2];

    logic [15:0] cap   [2][64];
    logic [15:0] cap_w [2];
    int          cap_n [2] = '{0, 0};
    int          cap_b [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_io   = 2'b00;

    int t0, base0, base1, dc0, dc1;

    always #5 clk = ~clk;

    ds1302_time_writer #(.SCLK_HALF(H), .CLEAR_WP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .hr_bcd(hr), .min_bcd(mn), .sec_bcd(sc),
        .ce(ce[0]), .sclk(sclk[0]), .io_out(io_out[0]), .io_oe(io_oe[0]),
        .busy(busy[0]), .done(done[0])
    );

    ds1302_time_writer #(.SCLK_HALF(H), .CLEAR_WP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .hr_bcd(hr), .min_bcd(mn), .sec_bcd(sc),
        .ce(ce[1]), .sclk(sclk[1]), .io_out(io_out[1]), .io_oe(io_oe[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic int nfr(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    // frame k of instance d as {data, command}; register 0=WP,1=sec,2=min,3=hr
    function automatic logic [15:0] exp_word(input int d, input int k);
        int r;
        r = (d == 0) ? k + 1 : k;
        case (r)
            0:       return {8'h00, 8'h8E};
            1:       return {ms[d], 8'h80};
            2:       return {mm[d], 8'h82};
            default: return {mh[d], 8'h84};
        endcase
    endfunction

    // model: mt = cycles since the accepted start cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mact[d] <= 1'b0;
                mt[d]   <= 0;
            end else if (mact[d]) begin
                if (mt[d] == FR * nfr(d) + 1) mact[d] <= 1'b0;
                else mt[d] <= mt[d] + 1;
            end else if (start) begin
                mact[d] <= 1'b1;
                mt[d]   <= 1;
                ms[d]   <= sc & 8'h7F;
                mm[d]   <= mn;
                mh[d]   <= hr & 8'h3F;
            end
        end
    end

    initial begin : compare
        logic x_ce, x_sclk, x_io, x_oe, x_busy, x_done;
        bit   x_ckio;
        int   k, r, hf;
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    x_ce = 0; x_sclk = 0; x_io = 0; x_oe = 0; x_busy = 0; x_done = 0;
                    x_ckio = 1'b1;
                    if (mact[d]) begin
                        if (mt[d] == FR * nfr(d) + 1) begin
                            x_done = 1'b1;
                            x_ckio = 1'b0;
                        end else begin
                            k  = (mt[d] - 1) / FR;
                            r  = (mt[d] - 1) % FR;
                            hf = r / H;
                            w  = exp_word(d, k);
                            x_busy = 1'b1;
                            if (hf == 0) begin
                                x_ce = 1; x_oe = 1; x_io = w[0];
                            end else if (hf <= 32) begin
                                x_ce = 1; x_oe = 1;
                                x_sclk = ((hf - 1) % 2) == 1;
                                x_io = w[(hf - 1) / 2];
                            end else if (hf == 33) begin
                                x_ce = 1;
                                x_ckio = 1'b0;
                            end
                        end
                    end
                    chk($sformatf("d%0d ce t=%0d", d, mt[d]), ce[d], x_ce);
                    chk($sformatf("d%0d sclk t=%0d", d, mt[d]), sclk[d], x_sclk);
                    chk($sformatf("d%0d busy t=%0d", d, mt[d]), busy[d], x_busy);
                    chk($sformatf("d%0d done t=%0d", d, mt[d]), done[d], x_done);
                    if (x_ckio) begin
                        chk($sformatf("d%0d io_out t=%0d", d, mt[d]), io_out[d], x_io);
                        chk($sformatf("d%0d io_oe t=%0d", d, mt[d]), io_oe[d], x_oe);
                    end
                end
            end
        end
    end

    // bus sniffer: samples io on each sclk rise and assembles 16-bit frames
    initial begin : sniffer
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (chk_en && prev_sclk[d] == 1'b0 && sclk[d] == 1'b1) begin
                    chk($sformatf("d%0d io stable at rise", d), io_out[d], prev_io[d]);
                    cap_w[d][cap_b[d]] = io_out[d];
                    if (cap_b[d] == 15) begin
                        if (cap_n[d] < 64) cap[d][cap_n[d]] = cap_w[d];
                        cap_n[d]++;
                        cap_b[d] = 0;
                    end else begin
                        cap_b[d]++;
                    end
                end
                if (chk_en && done[d] === 1'b1) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                end
                if (rst) cap_b[d] = 0;
            end
            prev_sclk = sclk;
            prev_io   = io_out;
        end
    end

    // mode 0: plain; 1: extra start pulses; 2: reset on 7th rise of second frame
    task automatic run(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input int mode);
        @(posedge clk); #1;
        hr = h; mn = m; sc = s; start = 1'b1;
        t0 = cyc; base0 = cap_n[0]; base1 = cap_n[1];
        dc0 = done_cnt[0]; dc1 = done_cnt[1];
        for (int rel = 1; rel <= 320; rel++) begin
            @(posedge clk); #1;
            start = (mode == 1) && (rel == 50 || rel == 150 || rel == 229);
            rst   = (mode == 2) && (rel == 105);
            if (start) begin hr = 8'h11; mn = 8'h22; sc = 8'h33; end
            if (mode == 2 && rel == 106) begin
                @(negedge clk);
                chk("post-rst ce", 32'(ce), 32'd0);
                chk("post-rst sclk", 32'(sclk), 32'd0);
                chk("post-rst io_out", 32'(io_out), 32'd0);
                chk("post-rst io_oe", 32'(io_oe), 32'd0);
                chk("post-rst busy", 32'(busy), 32'd0);
                chk("post-rst done", 32'(done), 32'd0);
            end
        end
    endtask

    task automatic chk_frames(input int d, input int base, input int n,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e;
        chk($sformatf("d%0d frame count", d), 32'(cap_n[d] - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
            if (base + i < 64 && base + i < cap_n[d])
                chk($sformatf("d%0d frame %0d", d, i), 32'(cap[d][base + i]), 32'(e));
        end
    endtask

    task automatic chk_done(input int c0, input int c1);
        chk("d0 done pulses", 32'(done_cnt[0] - dc0), 32'd1);
        chk("d1 done pulses", 32'(done_cnt[1] - dc1), 32'd1);
        chk("d0 done cycle", 32'(done_cyc[0] - t0), 32'(c0));
        chk("d1 done cycle", 32'(done_cyc[1] - t0), 32'(c1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hr = 8'h00; mn = 8'h00; sc = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset ce", 32'(ce), 32'd0);
        chk("reset sclk", 32'(sclk), 32'd0);
        chk("reset io_out", 32'(io_out), 32'd0);
        chk("reset io_oe", 32'(io_oe), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);

        run(8'h23, 8'h59, 8'h45, 0);
        chk_done(229, 305);
        chk_frames(0, base0, 3, 16'h4580, 16'h5982, 16'h2384, 16'h0000);
        chk_frames(1, base1, 4, 16'h008E, 16'h4580, 16'h5982, 16'h2384);

        run(8'hE3, 8'h07, 8'hC5, 1);
        chk_done(229, 305);
        chk_frames(0, base0, 3, 16'h4580, 16'h0782, 16'h2384, 16'h0000);
        chk_frames(1, base1, 4, 16'h008E, 16'h4580, 16'h0782, 16'h2384);

        run(8'h23, 8'h59, 8'h45, 2);
        chk("rst run d0 no done", 32'(done_cnt[0] - dc0), 32'd0);
        chk("rst run d1 no done", 32'(done_cnt[1] - dc1), 32'd0);
        chk("rst run d0 frames", 32'(cap_n[0] - base0), 32'd1);
        chk("rst run d1 frames", 32'(cap_n[1] - base1), 32'd1);

        run(8'h12, 8'h34, 8'h56, 0);
        chk_done(229, 305);
        chk_frames(0, base0, 3, 16'h5680, 16'h3482, 16'h1284, 16'h0000);
        chk_frames(1, base1, 4, 16'h008E, 16'h5680, 16'h3482, 16'h1284);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
